// File: rtl/pipeline_skid_stage_pkg.sv
// Shared definitions for the ARM32 inter-stage pipeline buffer.
// - NOP_INSTR     : ARM "NOP" (MOV-hint encoding, cond=AL). It is placed in
//                   slots that are empty or whose instruction was killed.
// - epoch_t       : branch epoch tag type at the default tag width.
// - stage_entry_t : one buffered slot {instr, side, epoch} at the default
//                   widths. It is also the default entry type of the FIFO core.
package pipeline_pkg;

  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_SIDE_W  = 32;
  localparam int unsigned DEF_EPOCH_W = 1;

  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'hE320_F000;

  typedef logic [DEF_EPOCH_W-1:0] epoch_t;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_SIDE_W-1:0]  side;
    epoch_t                 epoch;
  } stage_entry_t;

endpackage

// File: rtl/pipeline_skid_stage_if.sv
// Handshake bundle for pipeline_skid_stage.
// - Upstream side   : in_valid/in_ready with in_instr, in_side and in_epoch.
// - Downstream side : out_valid/out_ready with out_instr, out_side and out_killed.
// - Control         : cur_epoch (the reference epoch) and flush.
// - Status          : squash_cnt.
// The slave modport is the stage's view of the bundle. The master modport
// is the view of the environment that drives the stage.
interface pipeline_skid_stage_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned SIDE_W  = 32,
  parameter int unsigned EPOCH_W = 1,
  parameter int unsigned CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [SIDE_W-1:0]  in_side;
  logic [EPOCH_W-1:0] in_epoch;
  logic [EPOCH_W-1:0] cur_epoch;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [SIDE_W-1:0]  out_side;
  logic               out_killed;
  logic [CNT_W-1:0]   squash_cnt;

  modport slave (
    input  in_valid, in_instr, in_side, in_epoch, cur_epoch, flush, out_ready,
    output in_ready, out_valid, out_instr, out_side, out_killed, squash_cnt
  );

  modport master (
    output in_valid, in_instr, in_side, in_epoch, cur_epoch, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_side, out_killed, squash_cnt
  );
endinterface

// File: rtl/pipeline_skid_stage_fifo_core.sv
// Circular buffer of DEPTH entries with registered full/empty flags.
// Ports:
// - clk, rst_n : clock and asynchronous active-low reset
// - push_i     : write request. It is ignored when the buffer is full or
//                when flush_i is high.
// - pop_i      : read request. It is ignored when the buffer is empty or
//                when flush_i is high.
// - flush_i    : clears the occupancy and both pointers at the clock edge
// - wr_data_i  : entry written at the write pointer
// - rd_data_o  : entry at the read pointer. It is meaningful only when
//                empty_o is low.
// - full_o     : occupancy == DEPTH
// - empty_o    : occupancy == 0
module stage_fifo_core
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = stage_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  logic   flush_i,
  input  entry_t wr_data_i,
  output entry_t rd_data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  entry_t           mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  // The buffer wraps at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (occ_q == OCC_W'(DEPTH));
  assign empty_o   = (occ_q == '0);
  assign push_ok   = push_i & ~full_o & ~flush_i;
  assign pop_ok    = pop_i & ~empty_o & ~flush_i;
  assign rd_data_o = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default at the top of the block, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wrap_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = wrap_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments, so all of them
  // update together at the edge, independent of the order of the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: the storage array has no reset. An entry is only read after it is
  // written, and the stage's outputs are gated by the occupancy, so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pipeline_skid_stage.sv
// Elastic inter-stage register for the ARM32 pipeline.
// Ports:
// - clk, rst_n : clock and asynchronous active-low reset
// - bus        : pipeline_skid_stage_if.slave. It carries the in_*/out_*
//                handshakes, cur_epoch, flush and squash_cnt.
// Behaviour:
// - in_ready depends only on the registered occupancy. There is no path
//   from out_ready to in_ready.
// - A head entry fetched under a stale epoch is shown as NOP_INSTR with
//   out_killed set. It must still be popped with out_ready.
// - squash_cnt counts killed pops and saturates at all-ones.
module pipeline_skid_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        SIDE_W    = 32,
  parameter int unsigned        EPOCH_W   = 1,
  parameter int unsigned        DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR,
  parameter int unsigned        CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_skid_stage_if.slave bus
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipeline_skid_stage: DEPTH must be in 1..4");
  end

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [SIDE_W-1:0]  side;
    logic [EPOCH_W-1:0] epoch;
  } entry_t;

  entry_t           wr_entry;
  entry_t           head;
  logic             full;
  logic             empty;
  logic             out_valid;
  logic             killed;
  logic             pop_fire;
  logic [CNT_W-1:0] squash_q, squash_d;

  assign wr_entry = '{instr: bus.in_instr, side: bus.in_side, epoch: bus.in_epoch};

  stage_fifo_core #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (bus.in_valid),
    .pop_i     (bus.out_ready),
    .flush_i   (bus.flush),
    .wr_data_i (wr_entry),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign out_valid = ~empty;
  // cur_epoch is compared at the head with no register in between, so a
  // branch redirect kills the head in the same cycle.
  assign killed    = out_valid & (head.epoch != bus.cur_epoch);
  // A flush discards any pop in its cycle, so flushed entries never count.
  assign pop_fire  = out_valid & bus.out_ready & ~bus.flush;

  assign bus.in_ready   = ~full;
  assign bus.out_valid  = out_valid;
  assign bus.out_killed = killed;
  assign bus.out_instr  = (out_valid && !killed) ? head.instr : NOP_INSTR;
  assign bus.out_side   = out_valid ? head.side : '0;
  assign bus.squash_cnt = squash_q;

  always_comb begin
    squash_d = squash_q;
    if (pop_fire && killed && (squash_q != '1)) squash_d = squash_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) squash_q <= '0;
    else        squash_q <= squash_d;
  end

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Directed testbench for pipeline_skid_stage. dut uses the default
// parameters. dut_sat uses CNT_W=2 to reach counter saturation.
module tb_pipeline_skid_stage;
  localparam logic [31:0] NOP = 32'hE320_F000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_skid_stage_if #(.INSTR_W(32), .SIDE_W(32), .EPOCH_W(1), .CNT_W(16)) ifa ();
  pipeline_skid_stage_if #(.INSTR_W(32), .SIDE_W(32), .EPOCH_W(1), .CNT_W(2))  ifb ();

  pipeline_skid_stage dut (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  pipeline_skid_stage #(.CNT_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.in_valid = 0; ifa.in_instr = '0; ifa.in_side = '0; ifa.in_epoch = '0;
    ifa.cur_epoch = 0; ifa.flush = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_instr = '0; ifb.in_side = '0; ifb.in_epoch = '0;
    ifb.cur_epoch = 0; ifb.flush = 0; ifb.out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", ifa.in_ready); end
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_instr !== NOP) begin n_err++; $display("FAIL rst_out_instr: got %h want %h", ifa.out_instr, NOP); end
    n_cmp++; if (ifa.out_side !== 32'h0) begin n_err++; $display("FAIL rst_out_side: got %h want 0", ifa.out_side); end
    n_cmp++; if (ifa.out_killed !== 1'b0) begin n_err++; $display("FAIL rst_out_killed: got %b want 0", ifa.out_killed); end
    n_cmp++; if (ifa.squash_cnt !== 16'd0) begin n_err++; $display("FAIL rst_squash: got %0d want 0", ifa.squash_cnt); end
  endtask

  task automatic test_streaming();
    ifa.out_ready = 1; ifa.in_valid = 1; ifa.in_epoch = 0; ifa.cur_epoch = 0;
    ifa.in_instr = 32'hE081_0002; ifa.in_side = 32'h0000_0100;
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b1) begin n_err++; $display("FAIL str_valid0: got %b want 1", ifa.out_valid); end
    n_cmp++; if (ifa.out_instr !== 32'hE081_0002) begin n_err++; $display("FAIL str_instr0: got %h want E0810002", ifa.out_instr); end
    n_cmp++; if (ifa.out_side !== 32'h100) begin n_err++; $display("FAIL str_side0: got %h want 100", ifa.out_side); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL str_ready0: got %b want 1", ifa.in_ready); end
    ifa.in_instr = 32'hE041_0003; ifa.in_side = 32'h0000_0104;
    tick();
    n_cmp++; if (ifa.out_instr !== 32'hE041_0003) begin n_err++; $display("FAIL str_instr1: got %h want E0410003", ifa.out_instr); end
    n_cmp++; if (ifa.out_killed !== 1'b0) begin n_err++; $display("FAIL str_killed1: got %b want 0", ifa.out_killed); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL str_ready1: got %b want 1", ifa.in_ready); end
    ifa.in_valid = 0;
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL str_drained: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_side !== 32'h0) begin n_err++; $display("FAIL str_side_empty: got %h want 0", ifa.out_side); end
  endtask

  task automatic test_backpressure();
    logic [31:0] p [3];
    p[0] = 32'hE1A0_0001; p[1] = 32'hE1A0_0002; p[2] = 32'hE1A0_0003;
    ifa.out_ready = 0; ifa.in_valid = 1; ifa.in_instr = p[0];
    tick();
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b want 1", ifa.in_ready); end
    ifa.in_instr = p[1];
    tick();
    n_cmp++; if (ifa.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %b want 0", ifa.in_ready); end
    ifa.in_instr = p[2];
    tick();
    n_cmp++; if (ifa.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_held: got %b want 0", ifa.in_ready); end
    n_cmp++; if (ifa.out_instr !== p[0]) begin n_err++; $display("FAIL bp_head0: got %h want %h", ifa.out_instr, p[0]); end
    // Full at this edge: the pop happens, the push of p[2] is refused.
    ifa.out_ready = 1;
    tick();
    n_cmp++; if (ifa.out_instr !== p[1]) begin n_err++; $display("FAIL bp_head1: got %h want %h", ifa.out_instr, p[1]); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_pop: got %b want 1", ifa.in_ready); end
    tick();
    ifa.in_valid = 0;
    n_cmp++; if (ifa.out_instr !== p[2]) begin n_err++; $display("FAIL bp_head2: got %h want %h", ifa.out_instr, p[2]); end
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", ifa.out_valid); end
  endtask

  task automatic test_epoch_squash();
    ifa.out_ready = 0; ifa.in_valid = 1; ifa.in_epoch = 0; ifa.cur_epoch = 0;
    ifa.in_instr = 32'hE280_1001; ifa.in_side = 32'h200;
    tick();
    ifa.in_instr = 32'hE280_1002; ifa.in_side = 32'h204;
    tick();
    ifa.in_valid = 0;
    n_cmp++; if (ifa.out_killed !== 1'b0) begin n_err++; $display("FAIL sq_live: got %b want 0", ifa.out_killed); end
    ifa.cur_epoch = 1;
    #1;
    n_cmp++; if (ifa.out_killed !== 1'b1) begin n_err++; $display("FAIL sq_killed: got %b want 1", ifa.out_killed); end
    n_cmp++; if (ifa.out_instr !== NOP) begin n_err++; $display("FAIL sq_nop: got %h want %h", ifa.out_instr, NOP); end
    n_cmp++; if (ifa.out_side !== 32'h200) begin n_err++; $display("FAIL sq_side: got %h want 200", ifa.out_side); end
    ifa.out_ready = 1;
    tick();
    tick();
    ifa.out_ready = 0;
    n_cmp++; if (ifa.squash_cnt !== 16'd2) begin n_err++; $display("FAIL sq_count: got %0d want 2", ifa.squash_cnt); end
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL sq_empty: got %b want 0", ifa.out_valid); end
    ifa.cur_epoch = 0;
  endtask

  task automatic test_flush();
    ifa.out_ready = 0; ifa.in_valid = 1; ifa.in_epoch = 0; ifa.cur_epoch = 0;
    ifa.in_instr = 32'hE352_0001;
    tick();
    ifa.in_instr = 32'hE352_0002;
    tick();
    // Stale head with out_ready high: the flush must win over the pop, and
    // the killed head must not be counted.
    ifa.cur_epoch = 1; ifa.out_ready = 1; ifa.flush = 1; ifa.in_instr = 32'hE352_0003;
    #1;
    n_cmp++; if (ifa.in_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_during: got %b want 0", ifa.in_ready); end
    tick();
    ifa.flush = 0;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_empty: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.squash_cnt !== 16'd2) begin n_err++; $display("FAIL fl_squash: got %0d want 2", ifa.squash_cnt); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready_after: got %b want 1", ifa.in_ready); end
    ifa.in_valid = 0;
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_push_dropped: got %b want 0", ifa.out_valid); end
    ifa.cur_epoch = 0; ifa.out_ready = 0;
  endtask

  task automatic test_async_reset();
    ifa.out_ready = 0; ifa.in_valid = 1; ifa.in_instr = 32'hE3A0_0007; ifa.in_side = 32'h300;
    tick();
    tick();
    ifa.in_valid = 0;
    n_cmp++; if (ifa.in_ready !== 1'b0) begin n_err++; $display("FAIL ar_full: got %b want 0", ifa.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready: got %b want 1", ifa.in_ready); end
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL ar_out_valid: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.out_instr !== NOP) begin n_err++; $display("FAIL ar_out_instr: got %h want %h", ifa.out_instr, NOP); end
    n_cmp++; if (ifa.out_side !== 32'h0) begin n_err++; $display("FAIL ar_out_side: got %h want 0", ifa.out_side); end
    n_cmp++; if (ifa.squash_cnt !== 16'd0) begin n_err++; $display("FAIL ar_squash: got %0d want 0", ifa.squash_cnt); end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL ar_post_empty: got %b want 0", ifa.out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    ifb.cur_epoch = 1; ifb.in_epoch = 0;
    for (int i = 0; i < 5; i++) begin
      ifb.in_valid = 1; ifb.out_ready = 0; ifb.in_instr = 32'hE000_0000 + 32'(i);
      tick();
      ifb.in_valid = 0; ifb.out_ready = 1;
      tick();
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_cmp++; if (ifb.squash_cnt !== want) begin n_err++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, ifb.squash_cnt, want); end
    end
    ifb.out_ready = 0;
    n_cmp++; if (ifb.out_valid !== 1'b0) begin n_err++; $display("FAIL sat_empty: got %b want 0", ifb.out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_epoch_squash();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_stage.md
Name: pipeline_skid_stage

Overview:
Parametrised inter-stage pipeline register for the ARM32 pipeline. It replaces the fixed single-register fetch/decode/memory stage units with a DEPTH-entry elastic buffer that uses a valid/ready handshake. Every entry carries an epoch tag. At the output, an entry whose epoch differs from the current branch epoch is replaced by the architectural NOP and flagged as killed. The stage also supports a full flush and counts squashed instructions for performance monitoring.

Parameters:
INSTR_W, 32, instruction word width
SIDE_W, 32, sideband payload width (PC, decoded flags, etc.)
EPOCH_W, 1, branch epoch tag width
DEPTH, 2, buffer entries; legal values 1..4
NOP_INSTR, 32'hE320F000, instruction substituted for killed or empty slots
CNT_W, 16, squash counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_instr  input  INSTR_W  incoming instruction
in_side  input  SIDE_W  incoming sideband payload
in_epoch  input  EPOCH_W  epoch the instruction was fetched under
cur_epoch  input  EPOCH_W  current branch epoch (reference)
flush  input  1  discard all buffered entries
out_valid  output  1  head entry available
out_ready  input  1  downstream accepts head
out_instr  output  INSTR_W  head instruction, or NOP_INSTR
out_side  output  SIDE_W  head sideband; zero when empty
out_killed  output  1  head valid but squashed by epoch mismatch
squash_cnt  output  CNT_W  saturating count of killed entries popped

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: buffer empty, read/write pointers 0, occupancy 0.
  - in_ready=1, out_valid=0, out_instr=NOP_INSTR, out_side=0, out_killed=0, squash_cnt=0.
  - Reset asserted mid-operation drops all entries immediately; no partial state survives.
- Storage: circular buffer of DEPTH entries, each holding {instr, side, epoch}. Pointers wrap modulo DEPTH. Occupancy register is 0..DEPTH.
- Push: on in_valid & in_ready at a rising edge, write at the write pointer and advance it.
- Pop: on out_valid & out_ready, advance the read pointer.
- Simultaneous push and pop: occupancy is unchanged.
- in_ready = (occupancy < DEPTH), driven from registers only. There is no combinational path from out_ready to in_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - With DEPTH=1 throughput is one instruction per two cycles. DEPTH>=2 sustains one per cycle.
- Latency: an instruction pushed at edge N appears on out_* after edge N (1 cycle) when the buffer was empty.
- out_valid = (occupancy != 0).
- Epoch squash (combinational at the head):
  - out_killed = out_valid & (head.epoch != cur_epoch).
  - out_instr = NOP_INSTR when out_killed or empty, otherwise head.instr.
  - out_side = head.side when out_valid, otherwise 0.
  - A change of cur_epoch takes effect on the head in the same cycle.
- Killed entries still require out_ready to pop. They are delivered as NOP so downstream bubble accounting stays uniform.
- Flush: at the edge where flush=1, occupancy and both pointers clear to 0.
  - A push or pop in that same cycle is discarded.
  - squash_cnt is not incremented by flushed entries.
  - in_ready remains driven by the pre-flush occupancy during the flush cycle.
- squash_cnt increments by 1 on each pop with out_killed=1 and saturates at all-ones. It is cleared only by reset.
- Out-of-range DEPTH is a static error: an elaboration-time assertion fires.

Decomposition:
- The shared package pipeline_pkg holds:
  - the NOP_INSTR constant (ARM NOP, cond=AL)
  - the epoch_t typedef
  - the stage_entry_t packed struct {instr, side, epoch}
- One natural sub-module: stage_fifo_core. It holds the pointers, occupancy, storage array and push/pop/flush logic.
- The top level adds the epoch comparison, NOP muxing and squash counter.

Test Plan:
1. Reset then idle: hold rst_n=0, then release with no input -> in_ready=1, out_valid=0, out_instr=32'hE320F000, squash_cnt=0.
2. Streaming, DEPTH=2, out_ready=1, push 0xE0810002 then 0xE0410003 on consecutive cycles with epoch=0, cur_epoch=0 -> each appears 1 cycle later in order, out_killed=0, in_ready stays 1.
3. Backpressure: out_ready=0, push 3 instructions -> in_ready falls after the 2nd push and the 3rd is held. Raise out_ready -> order preserved, no loss or duplication.
4. Epoch squash: buffer holds 2 entries with epoch=0; toggle cur_epoch to 1 -> same cycle out_killed=1, out_instr=NOP. After popping both, squash_cnt=2.
5. Flush with concurrent push: buffer holds 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy 0, squash_cnt unchanged.
6. Async reset mid-stream and counter saturation:
   - Drop rst_n between edges while the buffer is full -> outputs return to reset values without waiting for clk.
   - With CNT_W=2, pop 5 killed entries -> squash_cnt=3.
